gate_operand_loader: RTL and testbench

Upstream stage of the bitwise gate unit. It captures two operands, A and then B, from one shared byte bus under a load strobe. It holds them stable on a_q/b_q, which drive the gate stage's a/b inputs. It flags a complete pair with opnd_valid and keeps it until the consumer acknowledges.

---
 rtl/gate_opnd_pkg.sv | 13 +
 rtl/rise_detect.sv | 33 +++
 rtl/gate_operand_loader.sv | 93 +++++++++
 tb/tb_gate_operand_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_opnd_pkg.sv
// Shared types for the gate operand loader: sequencer state encoding and the
// operand width used by the gate stage.
package gate_opnd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_A = 2'd1,
    FULL   = 2'd2
  } opnd_state_t;

  localparam int GATE_W = 8;

endpackage

// File: rtl/rise_detect.sv
// Load-strobe rise detector. Optional two-flop input synchronizer is enabled by
// the GATE_LD_SYNC_EN macro.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic ld,
  output logic rise
);

  logic ld_src;
  logic ld_prev;

`ifdef GATE_LD_SYNC_EN
  logic [1:0] ld_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ld_sync <= 2'b00;
    else        ld_sync <= {ld_sync[0], ld};
  end

  assign ld_src = ld_sync[1];
`else
  assign ld_src = ld;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ld_prev <= 1'b0;
    else        ld_prev <= ld_src;
  end

  assign rise = ld_src & ~ld_prev;

endmodule

// File: rtl/gate_operand_loader.sv
// Captures operand A then B from a shared byte bus on ld rising edges and holds
// the pair for the gate stage until ack. Build option: GATE_LD_SYNC_EN.
module gate_operand_loader
  import gate_opnd_pkg::*;
#(
  parameter int WIDTH          = GATE_W,
  parameter int HOLD_AFTER_ACK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             ld,
  input  logic             ack,
  input  logic             clr,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             opnd_valid,
  output logic             busy,
  output logic             err
);

  opnd_state_t state;
  logic        ld_rise;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .ld    (ld),
    .rise  (ld_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      opnd_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      opnd_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        HAVE_A: begin
          if (ld_rise) begin
            b_q        <= din;
            state      <= FULL;
            opnd_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FULL: begin
          if (ack) begin
            if (HOLD_AFTER_ACK == 0) begin
              a_q <= '0;
              b_q <= '0;
            end
            opnd_valid <= 1'b0;
            // A strobe coinciding with ack starts the next pair immediately.
            if (ld_rise) begin
              a_q   <= din;
              state <= HAVE_A;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (ld_rise) begin
            err <= 1'b1;
          end
        end
        default: begin
          // IDLE, and the unused encoding which behaves as IDLE.
          opnd_valid <= 1'b0;
          if (ld_rise) begin
            a_q   <= din;
            state <= HAVE_A;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_operand_loader.sv
// Bench for gate_operand_loader: two instances (operands held / cleared after
// ack) driven in lockstep against an operand-count reference model.
module tb_gate_operand_loader;

  localparam int W = 8;
`ifdef GATE_LD_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int LAT  = 2;
`else
  localparam bit SYNC = 1'b0;
  localparam int LAT  = 0;
`endif

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         ld    = 1'b0;
  logic         ack   = 1'b0;
  logic         clr   = 1'b0;
  logic [W-1:0] din   = '0;

  logic [W-1:0] a_h, b_h, a_c, b_c;
  logic         v_h, bz_h, e_h, v_c, bz_c, e_c;

  int checks   = 0;
  int failures = 0;

  // Reference model: number of operands held (0..2), their values, sticky err.
  // Index 0 models the holding instance, index 1 the clearing instance.
  int           cnt [2];
  logic [W-1:0] ma  [2];
  logic [W-1:0] mb  [2];
  logic         merr[2];
  logic         mprev, s0, s1;

  always #5 clk = ~clk;

  gate_operand_loader #(.WIDTH(W), .HOLD_AFTER_ACK(1)) dut_h (
    .clk(clk), .reset(reset), .din(din), .ld(ld), .ack(ack), .clr(clr),
    .a_q(a_h), .b_q(b_h), .opnd_valid(v_h), .busy(bz_h), .err(e_h)
  );

  gate_operand_loader #(.WIDTH(W), .HOLD_AFTER_ACK(0)) dut_c (
    .clk(clk), .reset(reset), .din(din), .ld(ld), .ack(ack), .clr(clr),
    .a_q(a_c), .b_q(b_c), .opnd_valid(v_c), .busy(bz_c), .err(e_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; ma[i] = '0; mb[i] = '0; merr[i] = 1'b0;
    end
    mprev = 1'b0; s0 = 1'b0; s1 = 1'b0;
  endtask

  task automatic model_step();
    logic ldv, rise;
    ldv   = SYNC ? s1 : ld;
    rise  = ldv & ~mprev;
    mprev = ldv;
    s1    = s0;
    s0    = ld;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        cnt[i] = 0; ma[i] = '0; mb[i] = '0; merr[i] = 1'b0;
      end else if (cnt[i] == 2 && ack) begin
        if (i == 1) begin ma[i] = '0; mb[i] = '0; end
        if (rise) begin ma[i] = din; cnt[i] = 1; end
        else cnt[i] = 0;
      end else if (rise) begin
        if (cnt[i] == 0)      begin ma[i] = din; cnt[i] = 1; end
        else if (cnt[i] == 1) begin mb[i] = din; cnt[i] = 2; end
        else merr[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk(i ? "c_a"     : "h_a",     32'(i ? a_c  : a_h),  32'(ma[i]));
      chk(i ? "c_b"     : "h_b",     32'(i ? b_c  : b_h),  32'(mb[i]));
      chk(i ? "c_valid" : "h_valid", 32'(i ? v_c  : v_h),  32'(cnt[i] == 2));
      chk(i ? "c_busy"  : "h_busy",  32'(i ? bz_c : bz_h), 32'(cnt[i] != 0));
      chk(i ? "c_err"   : "h_err",   32'(i ? e_c  : e_h),  32'(merr[i]));
    end
  endtask

  task automatic cyc(input logic l, input logic [W-1:0] d, input logic a, input logic c);
    ld = l; din = d; ack = a; clr = c;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // One-cycle strobe, then enough quiet cycles for the synchronized path to land.
  task automatic pulse(input logic [W-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, d, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    chk("rst_a", 32'(a_h), 32'h0);
    chk("rst_busy", 32'(bz_h), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Basic pair capture.
    pulse(8'hA5);
    pulse(8'h3C);
    chk("tp1_a", 32'(a_h), 32'hA5);
    chk("tp1_b", 32'(b_h), 32'h3C);
    chk("tp1_valid", 32'(v_h), 32'h1);
    chk("tp1_busy", 32'(bz_h), 32'h1);

    // Level-held strobe loads exactly once.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (5) cyc(1'b1, 8'h11, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 8'h11, 1'b0, 1'b0);
    chk("tp2_a", 32'(a_h), 32'h11);
    chk("tp2_b", 32'(b_h), 32'h0);
    chk("tp2_busy", 32'(bz_h), 32'h1);
    chk("tp2_valid", 32'(v_h), 32'h0);

    // Overrun in FULL.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    pulse(8'hF0);
    pulse(8'h0F);
    pulse(8'h55);
    chk("tp3_err", 32'(e_h), 32'h1);
    chk("tp3_a", 32'(a_h), 32'hF0);
    chk("tp3_b", 32'(b_h), 32'h0F);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("tp3_ack_valid", 32'(v_h), 32'h0);
    chk("tp3_ack_err", 32'(e_h), 32'h1);

    // Ack and strobe in the same cycle.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    pulse(8'h01);
    pulse(8'h02);
    for (int i = 0; i <= LAT; i++) cyc(i == 0, 8'h77, i == LAT, 1'b0);
    repeat (3) cyc(1'b0, 8'h77, 1'b0, 1'b0);
    chk("tp4_valid", 32'(v_h), 32'h0);
    chk("tp4_a", 32'(a_h), 32'h77);
    chk("tp4_busy", 32'(bz_h), 32'h1);
    chk("tp4_c_a", 32'(a_c), 32'h77);
    chk("tp4_c_b", 32'(b_c), 32'h0);
    pulse(8'h88);
    chk("tp4_pair_a", 32'(a_h), 32'h77);
    chk("tp4_pair_b", 32'(b_h), 32'h88);
    chk("tp4_pair_valid", 32'(v_h), 32'h1);

    // Asynchronous reset in HAVE_A, no clock edge needed.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    pulse(8'h9C);
    chk("tp5_pre_a", 32'(a_h), 32'h9C);
    #2 reset = 1'b0;
    #1;
    chk("tp5_async_a", 32'(a_h), 32'h0);
    chk("tp5_async_busy", 32'(bz_h), 32'h0);
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // clr in FULL with err set.
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h03);
    chk("tp5_err", 32'(e_h), 32'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("tp5_clr_a", 32'(a_h), 32'h0);
    chk("tp5_clr_b", 32'(b_h), 32'h0);
    chk("tp5_clr_valid", 32'(v_h), 32'h0);
    chk("tp5_clr_err", 32'(e_h), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      cyc(1'($urandom_range(0, 2) == 0),
          8'($urandom),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 40) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
